// File: rtl/simon_pkg.sv
// Shared definitions for the SIMON byte loader: core load codes, loader state
// encoding and the default key/plaintext byte counts.
package simon_pkg;

  localparam int DEF_KEY_BYTES = 16;
  localparam int DEF_PT_BYTES  = 16;

  localparam logic [1:0] RDY_IDLE = 2'b00;
  localparam logic [1:0] RDY_PT   = 2'b01;
  localparam logic [1:0] RDY_KEY  = 2'b10;
  localparam logic [1:0] RDY_RUN  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } loader_state_e;

  function automatic logic [1:0] load_code(input logic is_key);
    return is_key ? RDY_KEY : RDY_PT;
  endfunction

endpackage

// File: rtl/simon_byte_loader_if.sv
// Byte-side handshake between the pin interface (master) and the loader (slave).
interface simon_byte_loader_if;

  // A byte transfers on every rising edge where byte_valid && byte_ready.
  // byte_ready never depends on byte_valid; the master holds byte_in and
  // byte_is_key stable while byte_valid is high and not yet accepted.
  logic [7:0] byte_in;
  logic       byte_is_key;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_in,
    output byte_is_key,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_in,
    input  byte_is_key,
    input  byte_valid,
    output byte_ready
  );

endinterface

// File: rtl/simon_bit_serializer.sv
// 8-bit parallel-in serial-out register, LSB first, with a 3-bit bit index
// and a last-bit flag. The serial output is taken straight from a flop.
module simon_bit_serializer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       shift,
  input  logic       clear,
  input  logic [7:0] din,
  output logic       bit_out,
  output logic [2:0] bit_idx,
  output logic       last
);

  logic [7:0] sh_q;
  logic [2:0] idx_q;

  // load has priority so a new byte can follow bit 7 without a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      idx_q <= '0;
    end else if (load) begin
      sh_q  <= din;
      idx_q <= '0;
    end else if (clear) begin
      sh_q  <= '0;
      idx_q <= '0;
    end else if (shift) begin
      sh_q  <= {1'b0, sh_q[7:1]};
      idx_q <= idx_q + 3'd1;
    end
  end

  assign bit_out = sh_q[0];
  assign bit_idx = idx_q;
  assign last    = (idx_q == 3'd7);

endmodule

// File: rtl/simon_byte_loader.sv
// Byte-to-bit front end for the bit-serial SIMON 128/128 core.
// Optional: define SIMON_LOADER_KEY_REUSE_EN to keep the key loaded across blocks.
module simon_byte_loader
  import simon_pkg::*;
#(
  parameter int KEY_BYTES = DEF_KEY_BYTES,
  parameter int PT_BYTES  = DEF_PT_BYTES
) (
  input  logic                clk,
  input  logic                rst_n,
  simon_byte_loader_if.slave  bus,
  input  logic                start,
  input  logic                core_valid,
  output logic                data_in,
  output logic [1:0]          data_rdy,
  output logic                busy,
  output logic                loaded,
  output logic                err,
  output loader_state_e       state_dbg,
  output logic [2:0]          bit_idx_dbg
);

  localparam int KW = $clog2(KEY_BYTES + 1);
  localparam int PW = $clog2(PT_BYTES + 1);
  localparam logic [KW-1:0] KEY_FULL = KW'(KEY_BYTES);
  localparam logic [PW-1:0] PT_FULL  = PW'(PT_BYTES);

  loader_state_e state_q, state_d;
  logic [1:0]    rdy_q, rdy_d;
  logic [KW-1:0] key_cnt_q;
  logic [PW-1:0] pt_cnt_q;
  logic          err_q;

  logic key_inc, pt_inc, key_clr, pt_clr, err_set;
  logic ser_load, ser_shift, ser_clear, ser_last, ser_bit;
  logic byte_ready_c, loaded_c;
  logic take, room, accept_new, drop;

  simon_bit_serializer u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ser_load),
    .shift   (ser_shift),
    .clear   (ser_clear),
    .din     (bus.byte_in),
    .bit_out (ser_bit),
    .bit_idx (bit_idx_dbg),
    .last    (ser_last)
  );

  // State register, counters, sticky error and the registered load code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rdy_q     <= RDY_IDLE;
      key_cnt_q <= '0;
      pt_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      if (key_clr)      key_cnt_q <= '0;
      else if (key_inc) key_cnt_q <= key_cnt_q + KW'(1);
      if (pt_clr)       pt_cnt_q  <= '0;
      else if (pt_inc)  pt_cnt_q  <= pt_cnt_q + PW'(1);
      if (err_set)      err_q     <= 1'b1;
    end
  end

  // A byte whose class counter is already full is still taken, but dropped.
  assign take       = bus.byte_valid && byte_ready_c;
  assign room       = bus.byte_is_key ? (key_cnt_q != KEY_FULL) : (pt_cnt_q != PT_FULL);
  assign accept_new = take && room;
  assign drop       = take && !room;

  // Next-state, next load code and datapath controls.
  always_comb begin
    state_d   = state_q;
    rdy_d     = rdy_q;
    key_inc   = 1'b0;
    pt_inc    = 1'b0;
    key_clr   = 1'b0;
    pt_clr    = 1'b0;
    err_set   = 1'b0;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    ser_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_new) begin
          state_d  = ST_SHIFT;
          rdy_d    = load_code(bus.byte_is_key);
          ser_load = 1'b1;
          key_inc  = bus.byte_is_key;
          pt_inc   = !bus.byte_is_key;
        end else if (start && !bus.byte_valid && loaded_c) begin
          state_d = ST_RUN;
          rdy_d   = RDY_RUN;
        end
        // a simultaneous byte beats start; start then only matters when unloaded
        if (drop || (start && !loaded_c)) err_set = 1'b1;
      end
      ST_SHIFT: begin
        if (start) err_set = 1'b1;
        if (!ser_last) begin
          ser_shift = 1'b1;
        end else if (accept_new) begin
          rdy_d    = load_code(bus.byte_is_key);
          ser_load = 1'b1;
          key_inc  = bus.byte_is_key;
          pt_inc   = !bus.byte_is_key;
        end else begin
          state_d   = ST_IDLE;
          rdy_d     = RDY_IDLE;
          ser_clear = 1'b1;
          if (drop) err_set = 1'b1;
        end
      end
      ST_RUN: begin
        if (start) err_set = 1'b1;
        if (core_valid) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (start) err_set = 1'b1;
        if (!core_valid) begin
          state_d = ST_IDLE;
          rdy_d   = RDY_IDLE;
          pt_clr  = 1'b1;
`ifdef SIMON_LOADER_KEY_REUSE_EN
          key_clr = 1'b0;
`else
          key_clr = 1'b1;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        rdy_d   = RDY_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    byte_ready_c = (state_q == ST_IDLE) || ((state_q == ST_SHIFT) && ser_last);
    busy         = (state_q == ST_SHIFT) || (state_q == ST_RUN);
    loaded_c     = (key_cnt_q == KEY_FULL) && (pt_cnt_q == PT_FULL);
  end

  assign bus.byte_ready = byte_ready_c;
  assign loaded         = loaded_c;
  assign err            = err_q;
  assign data_rdy       = rdy_q;
  assign data_in        = ser_bit;
  assign state_dbg      = state_q;

endmodule
